// File: rtl/fact_pkg.sv
// Shared constants and state encoding for the factorial accelerator bus master.
// Address values match the slave's A[3:2] register select.
package fact_pkg;

  localparam logic [1:0] ADDR_N      = 2'b00;
  localparam logic [1:0] ADDR_GO     = 2'b01;
  localparam logic [1:0] ADDR_STATUS = 2'b10;
  localparam logic [1:0] ADDR_RESULT = 2'b11;

  localparam int STATUS_DONE = 0;
  localparam int STATUS_ERR  = 1;

  localparam int FACT_MAX_N = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_N,
    S_WR_GO,
    S_CLR_GO,
    S_POLL,
    S_RD_RES,
    S_RESP
  } state_t;

endpackage

// File: rtl/fact_bus_master.sv
// Bus initiator for the factorial accelerator: takes n on a request port,
// writes N and a GO pulse, polls STATUS, reads RESULT and returns it on a response port.
module fact_bus_master
  import fact_pkg::*;
#(
  parameter int POLL_LIMIT = 255,
  parameter int CNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_n,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        busy,
  output logic [1:0]  A,
  output logic        WE,
  output logic [3:0]  WD,
  input  logic [31:0] RD
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_LIMIT - 1);

  state_t           state_reg, state_next;
  logic [3:0]       n_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      result_reg;
  logic             err_reg;
  logic             timeout_reg;

  logic st_done, st_err;
  assign st_done = RD[STATUS_DONE];
  assign st_err  = RD[STATUS_ERR];

  assign rsp_result  = result_reg;
  assign rsp_err     = err_reg;
  assign rsp_timeout = timeout_reg;

  // Bus outputs are pure state decode (plus the captured n), never from RD.
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    A          = ADDR_N;
    WE         = 1'b0;
    WD         = 4'd0;
    case (state_reg)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_next = S_WR_N;
      end
      S_WR_N: begin
        WE         = 1'b1;
        WD         = n_reg;
        state_next = S_WR_GO;
      end
      S_WR_GO: begin
        A          = ADDR_GO;
        WE         = 1'b1;
        WD         = 4'd1;
        state_next = S_CLR_GO;
      end
      S_CLR_GO: begin
        A          = ADDR_GO;
        WE         = 1'b1;
        state_next = S_POLL;
      end
      S_POLL: begin
        A = ADDR_STATUS;
        if (st_done && st_err)       state_next = S_RESP;
        else if (st_done)            state_next = S_RD_RES;
        else if (cnt_reg == CNT_LAST) state_next = S_RESP;
      end
      S_RD_RES: begin
        A          = ADDR_RESULT;
        state_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      n_reg       <= 4'd0;
      cnt_reg     <= '0;
      result_reg  <= 32'd0;
      err_reg     <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE:   if (req_valid) n_reg <= req_n;
        S_CLR_GO: cnt_reg <= '0;
        S_POLL: begin
          cnt_reg <= cnt_reg + 1'b1;
          // Error beats done: the result register is never read on error.
          if (st_done && st_err) begin
            result_reg  <= 32'd0;
            err_reg     <= 1'b1;
            timeout_reg <= 1'b0;
          end else if (!st_done && cnt_reg == CNT_LAST) begin
            result_reg  <= 32'd0;
            err_reg     <= 1'b1;
            timeout_reg <= 1'b1;
          end
        end
        S_RD_RES: begin
          result_reg  <= RD;
          err_reg     <= 1'b0;
          timeout_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fact_bus_master.sv
// Directed bench for fact_bus_master against a behavioural factorial slave
// with configurable done latency and a never-done stub mode.
module tb_fact_bus_master;

  localparam int PL = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_n = 4'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        busy;
  logic [1:0]  A;
  logic        WE;
  logic [3:0]  WD;
  logic [31:0] RD;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fact_bus_master #(.POLL_LIMIT(PL), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_n(req_n),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .busy(busy), .A(A), .WE(WE), .WD(WD), .RD(RD)
  );

  // Behavioural slave
  logic [3:0]  s_n;
  logic        s_done, s_err;
  logic [31:0] s_res;
  int          s_pend;
  bit          stub = 1'b0;
  int          lat = 1;

  function automatic logic [31:0] fact(input logic [3:0] n);
    logic [31:0] r = 32'd1;
    for (int i = 2; i <= int'(n); i++) r = r * 32'(i);
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_n <= 4'd0; s_done <= 1'b0; s_err <= 1'b0; s_res <= 32'd0; s_pend <= 0;
    end else begin
      if (WE && A == 2'b00) s_n <= WD;
      if (WE && A == 2'b01 && WD[0]) begin
        s_done <= 1'b0; s_err <= 1'b0; s_res <= 32'd0;
        s_pend <= stub ? 0 : lat;
      end else if (s_pend != 0) begin
        s_pend <= s_pend - 1;
        if (s_pend == 1) begin
          s_done <= 1'b1;
          if (s_n > 4'd12) s_err <= 1'b1;
          else s_res <= fact(s_n);
        end
      end
    end
  end

  always_comb begin
    RD = 32'd0;
    case (A)
      2'b00: RD = {28'd0, s_n};
      2'b10: RD = {30'd0, s_err, s_done};
      2'b11: RD = s_res;
      default: RD = 32'd0;
    endcase
  end

  // Bus activity monitor; jobs take snapshot differences.
  int   we_cnt = 0, rd_res_cnt = 0, poll_cnt = 0;
  logic [3:0] go_prev = 4'd0, go_last = 4'd0;
  always @(posedge clk) begin
    if (rst) begin
      if (WE) we_cnt <= we_cnt + 1;
      if (WE && A == 2'b01) begin go_prev <= go_last; go_last <= WD; end
      if (busy && A == 2'b11) rd_res_cnt <= rd_res_cnt + 1;
      if (busy && A == 2'b10) poll_cnt <= poll_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_job(input string tag, input logic [3:0] n, input int l, input bit st,
                         input int bp, input logic [31:0] exp_res, input bit exp_err,
                         input bit exp_to, input int exp_polls);
    int we0, rd0, p0, cyc;
    logic [31:0] held;
    stub = st; lat = l;
    we0 = we_cnt; rd0 = rd_res_cnt; p0 = poll_cnt;
    @(negedge clk);
    check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_n = n;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    cyc = 0;
    while (!rsp_valid && cyc < 200) begin @(negedge clk); cyc++; end
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    check_eq({tag, "_result"}, rsp_result, exp_res);
    check_eq({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    check_eq({tag, "_timeout"}, 32'(rsp_timeout), 32'(exp_to));
    check_eq({tag, "_we_cycles"}, 32'(we_cnt - we0), 32'd3);
    check_eq({tag, "_go_seq"}, {24'd0, go_prev, go_last}, 32'h10);
    check_eq({tag, "_rd_result"}, 32'(rd_res_cnt - rd0), (exp_err ? 32'd0 : 32'd1));
    if (exp_polls > 0) check_eq({tag, "_polls"}, 32'(poll_cnt - p0), 32'(exp_polls));
    held = rsp_result;
    for (int i = 0; i < bp; i++) begin
      req_valid = 1'b1; req_n = 4'd7;
      @(negedge clk);
      check_eq({tag, "_bp_valid"}, 32'(rsp_valid), 32'd1);
      check_eq({tag, "_bp_stable"}, rsp_result, held);
      check_eq({tag, "_bp_req_ready"}, 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, "_done_ready"}, 32'(req_ready), 32'd1);
    $display("[TB] job %s n=%0d result=%0d err=%0d timeout=%0d", tag, n, held, rsp_err, rsp_timeout);
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_we", 32'(WE), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_A", 32'(A), 32'd0);
    check_eq("rst_result", rsp_result, 32'd0);
    rst = 1'b1;

    run_job("n5",  4'd5,  3, 1'b0, 0, 32'd120,       1'b0, 1'b0, 0);
    run_job("n12", 4'd12, 1, 1'b0, 0, 32'h1C8CFC00,  1'b0, 1'b0, 1);
    run_job("n0",  4'd0,  2, 1'b0, 0, 32'd1,         1'b0, 1'b0, 0);
    run_job("n13", 4'd13, 2, 1'b0, 0, 32'd0,         1'b1, 1'b0, 0);
    run_job("stub", 4'd3, 1, 1'b1, 0, 32'd0,         1'b1, 1'b1, PL);

    // Reset in the middle of a job
    stub = 1'b0; lat = 20;
    @(negedge clk);
    req_valid = 1'b1; req_n = 4'd5;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_we", 32'(WE), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_req_ready", 32'(req_ready), 32'd1);
    check_eq("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b1;
    $display("[TB] job midrst aborted");

    run_job("n4_bp", 4'd4, 2, 1'b0, 10, 32'd24,  1'b0, 1'b0, 0);
    run_job("n6",    4'd6, 1, 1'b0, 0,  32'd720, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
